// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths and FSM encoding for the data-memory arbiter
package dmem_arbiter_pkg;
    localparam int AW = 8;
    localparam int DW = 32;
    typedef enum logic {ST_NORMAL = 1'b0, ST_FORCE = 1'b1} state_e;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the MEM stage and a debug port with bounded debug wait
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic [DW-1:0] p_rdata,
    output logic          p_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);
    state_e        state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          d_valid_q, d_valid_d;
    logic          d_own, p_own;

    assign p_rdata = m_rdata;
    assign d_rdata = d_rdata_q;
    assign d_valid = d_valid_q;

    // ownership, memory mux, wait counter and next state; reset silences all grants and writes
    always_comb begin
        d_own     = rst && d_req && (state_q == ST_FORCE || !p_req);
        p_own     = rst && p_req && !d_own;
        d_gnt     = d_own;
        p_stall   = d_own && p_req;
        m_we      = d_own ? d_we : (p_own && p_we);
        m_addr    = d_own ? d_addr : p_addr;
        m_wdata   = d_own ? d_wdata : p_wdata;
        wait_d    = (d_req && !d_own) ? ((wait_q == 4'hF) ? wait_q : wait_q + 4'd1) : 4'd0;
        state_d   = (state_q == ST_NORMAL && d_req && !d_own && wait_q == 4'(MAX_WAIT - 1)) ? ST_FORCE : ST_NORMAL;
        d_valid_d = d_own && !d_we;
        d_rdata_d = d_valid_d ? m_rdata : d_rdata_q;
    end

    // state register, wait counter and registered debug read result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_NORMAL;
            wait_q    <= 4'd0;
            d_rdata_q <= '0;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            d_rdata_q <= d_rdata_d;
            d_valid_q <= d_valid_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a falling-edge-write memory model
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        p_req, p_we, d_req, d_we;
    logic [7:0]  p_addr, d_addr;
    logic [31:0] p_wdata, d_wdata;
    logic [31:0] p_rdata, d_rdata, m_wdata, m_rdata;
    logic        p_stall, d_gnt, d_valid, m_we;
    logic [7:0]  m_addr;
    logic [31:0] mem [256];
    logic [31:0] sb_q [$];
    int          errors = 0;
    int          checks = 0;

    dmem_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    assign m_rdata = mem[m_addr];

    always @(negedge clk) if (m_we === 1'b1) mem[m_addr] <= m_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && d_valid === 1'b1) begin
            if (sb_q.size() == 0) check("d_valid_spurious", 32'd1, 32'd0);
            else check("d_rdata", d_rdata, sb_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b1;
        p_req = 1'b1; p_we = 1'b1; p_addr = 8'h40; p_wdata = 32'hBAD0BAD0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h41; d_wdata = 32'hBAD1BAD1;
        #1 rst = 1'b0;
        tick();
        settle();
        check("rst_m_we", 32'(m_we), 32'd0);
        check("rst_p_stall", 32'(p_stall), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rst_d_valid", 32'(d_valid), 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        p_req = 1'b0; d_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        p_req = 1'b1; p_we = 1'b1; p_addr = 8'h10; p_wdata = 32'hDEADBEEF;
        settle();
        check("p_store_m_we", 32'(m_we), 32'd1);
        check("p_store_m_addr", 32'(m_addr), 32'h10);
        check("p_store_m_wdata", m_wdata, 32'hDEADBEEF);
        check("p_store_stall", 32'(p_stall), 32'd0);
        tick();
        p_we = 1'b0;
        settle();
        check("p_load_rdata", p_rdata, 32'hDEADBEEF);
        check("p_load_m_we", 32'(m_we), 32'd0);
        tick();
        p_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
        sb_q.push_back(32'hDEADBEEF);
        settle();
        check("d_only_gnt", 32'(d_gnt), 32'd1);
        check("d_only_m_addr", 32'(m_addr), 32'h10);
        tick();
        d_req = 1'b0;
        settle();
        check("d_only_valid", 32'(d_valid), 32'd1);
        tick();
        settle();
        check("d_valid_pulse", 32'(d_valid), 32'd0);
        check("d_rdata_hold", d_rdata, 32'hDEADBEEF);
        p_req = 1'b1; p_we = 1'b0; p_addr = 8'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
        sb_q.push_back(32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("starve_gnt_c%0d", i), 32'(d_gnt), 32'd0);
            check($sformatf("starve_stall_c%0d", i), 32'(p_stall), 32'd0);
            tick();
        end
        settle();
        check("starve_force_gnt", 32'(d_gnt), 32'd1);
        check("starve_force_stall", 32'(p_stall), 32'd1);
        check("starve_force_addr", 32'(m_addr), 32'h10);
        tick();
        d_req = 1'b0;
        settle();
        check("starve_after_stall", 32'(p_stall), 32'd0);
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("fw_gnt_c%0d", i), 32'(d_gnt), 32'd0);
            tick();
        end
        settle();
        check("fw_gnt", 32'(d_gnt), 32'd1);
        check("fw_stall", 32'(p_stall), 32'd1);
        check("fw_m_we", 32'(m_we), 32'd1);
        check("fw_m_addr", 32'(m_addr), 32'h20);
        check("fw_m_wdata", m_wdata, 32'h12345678);
        tick();
        d_req = 1'b0; p_addr = 8'h20;
        settle();
        check("fw_p_load", p_rdata, 32'h12345678);
        check("fw_no_valid", 32'(d_valid), 32'd0);
        check("fw_no_stall", 32'(p_stall), 32'd0);
        tick();
        p_we = 1'b1; p_addr = 8'h40; p_wdata = 32'hCAFEF00D;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("rmw_m_we", 32'(m_we), 32'd0);
        check("rmw_d_valid", 32'(d_valid), 32'd0);
        check("rmw_d_gnt", 32'(d_gnt), 32'd0);
        check("rmw_p_stall", 32'(p_stall), 32'd0);
        tick();
        rst = 1'b1;
        sb_q.push_back(32'h12345678);
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("rmw_gnt_c%0d", i), 32'(d_gnt), 32'd0);
            tick();
        end
        settle();
        check("rmw_gnt", 32'(d_gnt), 32'd1);
        check("rmw_stall", 32'(p_stall), 32'd1);
        check("rmw_grant_no_write", 32'(m_we), 32'd0);
        tick();
        d_req = 1'b0; p_we = 1'b0; p_addr = 8'h40;
        settle();
        check("rmw_p_store_done", p_rdata, 32'hCAFEF00D);
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
        for (int i = 0; i < 4; i++) tick();
        d_req = 1'b0;
        settle();
        check("pv_stall", 32'(p_stall), 32'd0);
        check("pv_gnt", 32'(d_gnt), 32'd0);
        check("pv_m_addr", 32'(m_addr), 32'h40);
        tick();
        d_req = 1'b1;
        settle();
        check("pv_normal_gnt", 32'(d_gnt), 32'd0);
        check("pv_normal_stall", 32'(p_stall), 32'd0);
        tick();
        d_req = 1'b0; p_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
        sb_q.push_back(32'hDEADBEEF);
        settle();
        check("b2b_gnt0", 32'(d_gnt), 32'd1);
        tick();
        d_addr = 8'h20;
        sb_q.push_back(32'h12345678);
        settle();
        check("b2b_gnt1", 32'(d_gnt), 32'd1);
        tick();
        d_req = 1'b0;
        tick();
        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
